// File: rtl/serv_mtimer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, mtimecmp compare and a
// Wishbone slave port for 32-bit single-beat register access.
module serv_mtimer #(
    parameter int PRESCALE_W     = 8,
    parameter     RESET_STRATEGY = "MINI"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_mtip
);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic [31:0]           mtime_hi_shadow;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic                  access;
    logic                  wr;
    logic                  rd_lo;
    logic                  tick;
    logic [31:0]           wmask;
    logic [31:0]           rd_data;

    assign access = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr     = access & i_wb_we;
    assign rd_lo  = access & ~i_wb_we & (i_wb_adr == 3'd0);
    assign tick   = (pcnt == prescale);
    assign wmask  = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};

    always_comb begin
        rd_data = '0;
        case (i_wb_adr)
            3'd0:    rd_data = mtime[31:0];
            3'd1:    rd_data = mtime_hi_shadow;
            3'd2:    rd_data = mtimecmp[31:0];
            3'd3:    rd_data = mtimecmp[63:32];
            3'd4:    rd_data = 32'(prescale);
            default: rd_data = '0;
        endcase
    end

    // A write to either mtime half suppresses the tick so the halves stay independent.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
            prescale <= '0;
            pcnt     <= '0;
            o_wb_ack <= 1'b0;
            o_mtip   <= 1'b0;
        end else begin
            o_wb_ack <= access;
            o_mtip   <= (mtime >= mtimecmp);

            if (wr && (i_wb_adr == 3'd4) || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PRESCALE_W'(1);

            if (wr && (i_wb_adr == 3'd0))
                mtime[31:0] <= (mtime[31:0] & ~wmask) | (i_wb_dat & wmask);
            else if (wr && (i_wb_adr == 3'd1))
                mtime[63:32] <= (mtime[63:32] & ~wmask) | (i_wb_dat & wmask);
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr && (i_wb_adr == 3'd2))
                mtimecmp[31:0] <= (mtimecmp[31:0] & ~wmask) | (i_wb_dat & wmask);
            if (wr && (i_wb_adr == 3'd3))
                mtimecmp[63:32] <= (mtimecmp[63:32] & ~wmask) | (i_wb_dat & wmask);
            if (wr && (i_wb_adr == 3'd4))
                prescale <= (prescale & ~wmask[PRESCALE_W-1:0]) |
                            (i_wb_dat[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);
        end
    end

    if (RESET_STRATEGY == "NONE") begin : g_noreset
        always_ff @(posedge i_clk) begin
            if (access)
                o_wb_rdt <= rd_data;
            if (rd_lo)
                mtime_hi_shadow <= mtime[63:32];
        end
    end else begin : g_reset
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                o_wb_rdt        <= '0;
                mtime_hi_shadow <= '0;
            end else begin
                if (access)
                    o_wb_rdt <= rd_data;
                if (rd_lo)
                    mtime_hi_shadow <= mtime[63:32];
            end
        end
    end

endmodule

// File: tb/tb_serv_mtimer.sv
// Self-checking bench for serv_mtimer: directed scenarios plus random bus
// traffic compared every cycle against an arithmetic reference model.
module tb_serv_mtimer;

    logic        i_clk    = 1'b0;
    logic        i_rst    = 1'b1;
    logic [2:0]  i_wb_adr = '0;
    logic [31:0] i_wb_dat = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        i_wb_we  = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_mtip;

    serv_mtimer #(.PRESCALE_W(8), .RESET_STRATEGY("MINI")) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_sel (i_wb_sel),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .i_wb_stb (i_wb_stb),
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack),
        .o_mtip   (o_mtip)
    );

    always #5 i_clk = ~i_clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference state; ticks are derived from the edge count since the last
    // prescale write rather than from a modelled prescale counter.
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_shadow, m_rdt;
    logic [7:0]  m_pre;
    logic        m_ack, m_mtip, m_rd;
    longint      k, a;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_time = '0; m_cmp = '1; m_pre = '0; m_shadow = '0; m_rdt = '0;
        m_ack = 1'b0; m_mtip = 1'b0; m_rd = 1'b0;
        k = 0; a = 0;
    endtask

    task automatic step();
        logic        acc, tick;
        logic [31:0] rdata;
        logic [63:0] t_n, c_n;
        logic [7:0]  p_n;
        @(posedge i_clk);
        acc  = i_wb_cyc && i_wb_stb && !m_ack;
        tick = ((k - a) % (longint'(m_pre) + 1)) == longint'(m_pre);
        case (i_wb_adr)
            3'd0:    rdata = m_time[31:0];
            3'd1:    rdata = m_shadow;
            3'd2:    rdata = m_cmp[31:0];
            3'd3:    rdata = m_cmp[63:32];
            3'd4:    rdata = {24'd0, m_pre};
            default: rdata = 32'd0;
        endcase
        t_n = tick ? m_time + 64'd1 : m_time;
        c_n = m_cmp;
        p_n = m_pre;
        if (acc && i_wb_we) begin
            case (i_wb_adr)
                3'd0: t_n = {m_time[63:32], lanes(m_time[31:0], i_wb_dat, i_wb_sel)};
                3'd1: t_n = {lanes(m_time[63:32], i_wb_dat, i_wb_sel), m_time[31:0]};
                3'd2: c_n = {m_cmp[63:32], lanes(m_cmp[31:0], i_wb_dat, i_wb_sel)};
                3'd3: c_n = {lanes(m_cmp[63:32], i_wb_dat, i_wb_sel), m_cmp[31:0]};
                3'd4: begin
                    if (i_wb_sel[0]) p_n = i_wb_dat[7:0];
                    a = k + 1;
                end
                default: ;
            endcase
        end
        if (acc && !i_wb_we && i_wb_adr == 3'd0) m_shadow = m_time[63:32];
        if (acc) m_rdt = rdata;
        m_rd   = acc && !i_wb_we;
        m_mtip = (m_time >= m_cmp);
        m_ack  = acc;
        m_time = t_n;
        m_cmp  = c_n;
        m_pre  = p_n;
        k++;
        #1;
        check("ack", o_wb_ack, m_ack);
        check("mtip", o_mtip, m_mtip);
        if (m_ack && m_rd) check("rdt", o_wb_rdt, m_rdt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic xfer(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdt);
        if (m_ack) step();
        i_wb_adr = adr; i_wb_we = we; i_wb_dat = dat; i_wb_sel = sel;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        step();
        rdt = o_wb_rdt;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        xfer(adr, 1'b1, dat, 4'hF, dummy);
    endtask

    task automatic rd(input logic [2:0] adr, output logic [31:0] v);
        xfer(adr, 1'b0, 32'd0, 4'hF, v);
    endtask

    task automatic do_reset();
        #2;
        i_rst = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        #1;
        check("rst_ack", o_wb_ack, 1'b0);
        check("rst_mtip", o_mtip, 1'b0);
        check("rst_rdt", o_wb_rdt, 32'd0);
        repeat (2) @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] v, v1;
        int          rise, acks;
        model_reset();
        do_reset();

        // reset state and free-running count
        idle(10);
        rd(3'd0, v);
        check("rst_cnt", (v >= 9 && v <= 10), 1'b1);
        rd(3'd2, v); check("rst_cmp_lo", v, 32'hFFFF_FFFF);
        rd(3'd3, v); check("rst_cmp_hi", v, 32'hFFFF_FFFF);
        rd(3'd4, v); check("rst_pre", v, 32'd0);
        rd(3'd0, v);
        do_reset();

        // prescaler
        wr(3'd4, 32'd3);
        wr(3'd0, 32'd0);
        idle(40);
        rd(3'd0, v);
        check("pre3_cnt", (v >= 9 && v <= 11), 1'b1);
        wr(3'd4, 32'd0);
        rd(3'd0, v1);
        idle(5);
        rd(3'd0, v);
        check("pre0_rate", v - v1, 32'd6);

        // compare / interrupt
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd2, 32'd20);
        rise = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (o_mtip && rise < 0) begin
                rise = i;
                break;
            end
        end
        check("mtip_rise", 64'(rise), 64'(19));
        wr(3'd2, 32'hFFFF_FFFF);
        check("mtip_hold", o_mtip, 1'b1);
        step();
        check("mtip_fall", o_mtip, 1'b0);

        // carry and wrap
        wr(3'd1, 32'd0);
        wr(3'd0, 32'hFFFF_FFFE);
        idle(2);
        rd(3'd0, v); check("carry_lo", v, 32'd0);
        rd(3'd1, v); check("carry_hi", v, 32'd1);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FFFF);
        rd(3'd0, v); check("wrap_lo", v, 32'd0);
        rd(3'd1, v); check("wrap_hi", v, 32'd0);

        // byte-lane write colliding with a tick
        wr(3'd0, 32'h1234_5600);
        xfer(3'd0, 1'b1, 32'h0000_00AA, 4'b0001, v);
        rd(3'd0, v);
        check("byte_coll", v, 32'h1234_56AB);

        // strobe held for six cycles
        if (m_ack) step();
        i_wb_adr = 3'd2; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        acks = 0;
        repeat (6) begin
            step();
            if (o_wb_ack) acks++;
        end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        check("held_acks", 64'(acks), 64'(3));

        // unmapped addresses
        for (int ad = 5; ad < 8; ad++) begin
            rd(3'(ad), v);
            check("unmap_rd", v, 32'd0);
            wr(3'(ad), 32'hFFFF_FFFF);
        end
        rd(3'd2, v); check("unmap_cmp_lo", v, 32'hFFFF_FFFF);
        rd(3'd3, v); check("unmap_cmp_hi", v, 32'd0);
        rd(3'd4, v); check("unmap_pre", v, 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            i_wb_cyc = ($urandom_range(0, 3) != 0);
            i_wb_stb = ($urandom_range(0, 3) != 0);
            i_wb_we  = 1'($urandom_range(0, 1));
            i_wb_adr = 3'($urandom_range(0, 7));
            i_wb_sel = 4'($urandom);
            i_wb_dat = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 64);
            if (i_wb_adr == 3'd4) i_wb_dat = $urandom_range(0, 3);
            step();
        end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        step();
        do_reset();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
